// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon AEAD control path.
package ascon_pkg;

  localparam int unsigned ASCON_MAX_ROUNDS = 12;
  localparam int unsigned ASCON_RND_IDX_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DELAY,
    ST_INIT_PERM,
    ST_INIT_END,
    ST_WAIT_AD,
    ST_AD_PERM,
    ST_AD_END,
    ST_WAIT_MSG,
    ST_MSG_PERM,
    ST_WAIT_LAST,
    ST_FIN_PERM,
    ST_FIN_END,
    ST_TAG_CHK,
    ST_DONE
  } ascon_ctrl_state_t;

  function automatic logic is_perm(ascon_ctrl_state_t s);
    return (s == ST_INIT_PERM) || (s == ST_AD_PERM) ||
           (s == ST_MSG_PERM)  || (s == ST_FIN_PERM);
  endfunction

endpackage

// File: rtl/ascon_rnd_cnt.sv
// Permutation round counter: remaining-cycle down-counter plus the Ascon
// round-constant index of the first round computed in the current cycle.
module ascon_rnd_cnt
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic                       i_en,
  input  logic [ASCON_RND_IDX_W-1:0] i_cnt_init,
  input  logic [ASCON_RND_IDX_W-1:0] i_idx_init,
  output logic [ASCON_RND_IDX_W-1:0] o_idx,
  output logic                       o_last_c
);

  logic [ASCON_RND_IDX_W-1:0] r_cnt;
  logic [ASCON_RND_IDX_W-1:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_cnt <= i_cnt_init;
      r_idx <= i_idx_init;
    end else if (i_en) begin
      r_cnt <= r_cnt - ASCON_RND_IDX_W'(1);
      r_idx <= r_idx + ASCON_RND_IDX_W'(UNROLL);
    end
  end

  assign o_idx    = r_idx;
  assign o_last_c = (r_cnt == '0);

endmodule

// File: rtl/ascon_aead_ctrl.sv
// Ascon AEAD control FSM: sequences init, AD, message and finalisation
// permutations for encrypt/decrypt and produces the decrypt tag verdict.
module ascon_aead_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6,
  parameter int unsigned UNROLL   = 1,
  parameter int unsigned BLK_W    = 8,
  parameter int unsigned DELAY_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               decrypt_i,
  input  logic [BLK_W-1:0]   ad_blks_i,
  input  logic [BLK_W-1:0]   msg_blks_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic               data_valid_i,
  input  logic               tag_match_i,
  output logic               data_req_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               load_state_o,
  output logic [3:0]         rnd_idx_o,
  output logic               sel_state_init_o,
  output logic               sel_xor_init_o,
  output logic               sel_xor_ext_o,
  output logic               sel_xor_dom_sep_o,
  output logic               sel_xor_fin_o,
  output logic               sel_xor_tag_o,
  output logic               sel_ct_replace_o,
  output logic               out_valid_o,
  output logic               tag_valid_o,
  output logic               auth_ok_o,
  output logic               auth_fail_o
);

  generate
    if (UNROLL == 0) begin : g_bad_unroll_zero
      $error("ascon_aead_ctrl: UNROLL must be non-zero");
    end else if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_unroll
      $error("ascon_aead_ctrl: UNROLL must divide ROUNDS_A and ROUNDS_B");
    end
    if (ROUNDS_A < 1 || ROUNDS_A > ASCON_MAX_ROUNDS ||
        ROUNDS_B < 1 || ROUNDS_B > ASCON_MAX_ROUNDS) begin : g_bad_rounds
      $error("ascon_aead_ctrl: round counts must be in 1..12");
    end
  endgenerate

  localparam int unsigned CYC_A = ROUNDS_A / UNROLL;
  localparam int unsigned CYC_B = ROUNDS_B / UNROLL;
  localparam logic [ASCON_RND_IDX_W-1:0] CNT_A = ASCON_RND_IDX_W'(CYC_A - 1);
  localparam logic [ASCON_RND_IDX_W-1:0] CNT_B = ASCON_RND_IDX_W'(CYC_B - 1);
  localparam logic [ASCON_RND_IDX_W-1:0] IDX_A = ASCON_RND_IDX_W'(ASCON_MAX_ROUNDS - ROUNDS_A);
  localparam logic [ASCON_RND_IDX_W-1:0] IDX_B = ASCON_RND_IDX_W'(ASCON_MAX_ROUNDS - ROUNDS_B);

  ascon_ctrl_state_t r_state;
  ascon_ctrl_state_t w_next;
  ascon_ctrl_state_t w_route;
  logic               r_first;
  logic               r_decrypt;
  logic               r_need_dom;
  logic               r_auth_ok;
  logic               r_auth_fail;
  logic [BLK_W-1:0]   r_ad_cnt;
  logic [BLK_W-1:0]   r_msg_cnt;
  logic [DELAY_W-1:0] r_delay_cnt;
  logic               w_start;
  logic               w_cnt_load;
  logic               w_use_a;
  logic               w_last;
  logic [ASCON_RND_IDX_W-1:0] w_idx;

  assign w_start    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start_i;
  assign w_cnt_load = is_perm(w_next) && (w_next != r_state);
  assign w_use_a    = (w_next == ST_INIT_PERM) || (w_next == ST_FIN_PERM);

  ascon_rnd_cnt #(
    .UNROLL (UNROLL)
  ) u_rnd_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_cnt_load),
    .i_en       (is_perm(r_state)),
    .i_cnt_init (w_use_a ? CNT_A : CNT_B),
    .i_idx_init (w_use_a ? IDX_A : IDX_B),
    .o_idx      (w_idx),
    .o_last_c   (w_last)
  );

  // r_first marks the first cycle spent in any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_decrypt   <= 1'b0;
      r_need_dom  <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_auth_fail <= 1'b0;
      r_ad_cnt    <= '0;
      r_msg_cnt   <= '0;
      r_delay_cnt <= '0;
    end else begin
      if (w_start) begin
        r_decrypt   <= decrypt_i;
        r_need_dom  <= (ad_blks_i != '0);
        r_auth_ok   <= 1'b0;
        r_auth_fail <= 1'b0;
        r_ad_cnt    <= ad_blks_i;
        r_msg_cnt   <= (msg_blks_i == '0) ? '0 : msg_blks_i - BLK_W'(1);
        r_delay_cnt <= delay_i;
      end
      if (r_state == ST_DELAY) r_delay_cnt <= r_delay_cnt - DELAY_W'(1);
      // Block counts drop as each block is accepted.
      if (r_state == ST_WAIT_AD && data_valid_i) r_ad_cnt <= r_ad_cnt - BLK_W'(1);
      if (r_state == ST_WAIT_MSG && data_valid_i) r_msg_cnt <= r_msg_cnt - BLK_W'(1);
      if (r_state == ST_AD_END) r_need_dom <= 1'b0;
      if (r_state == ST_TAG_CHK) begin
        r_auth_ok   <= tag_match_i;
        r_auth_fail <= !tag_match_i;
      end
    end
  end

  always_comb begin
    w_route = ST_WAIT_LAST;
    if (r_ad_cnt != '0)       w_route = ST_WAIT_AD;
    else if (r_need_dom)      w_route = ST_AD_END;
    else if (r_msg_cnt != '0) w_route = ST_WAIT_MSG;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start_i) w_next = ST_LOAD;
      ST_LOAD:      w_next = (r_delay_cnt != '0) ? ST_DELAY : ST_INIT_PERM;
      ST_DELAY:     if (r_delay_cnt <= DELAY_W'(1)) w_next = ST_INIT_PERM;
      ST_INIT_PERM: if (w_last) w_next = ST_INIT_END;
      ST_INIT_END:  w_next = w_route;
      ST_WAIT_AD:   if (data_valid_i) w_next = ST_AD_PERM;
      ST_AD_PERM:   if (w_last) w_next = w_route;
      ST_AD_END:    w_next = (r_msg_cnt != '0) ? ST_WAIT_MSG : ST_WAIT_LAST;
      ST_WAIT_MSG:  if (data_valid_i) w_next = ST_MSG_PERM;
      ST_MSG_PERM:  if (w_last) w_next = w_route;
      ST_WAIT_LAST: if (data_valid_i) w_next = ST_FIN_PERM;
      ST_FIN_PERM:  if (w_last) w_next = ST_FIN_END;
      ST_FIN_END:   w_next = r_decrypt ? ST_TAG_CHK : ST_DONE;
      ST_TAG_CHK:   w_next = ST_DONE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    data_req_o        = 1'b0;
    ready_o           = (r_state == ST_IDLE) || (r_state == ST_DONE);
    busy_o            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done_o            = 1'b0;
    load_state_o      = 1'b0;
    rnd_idx_o         = '0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    sel_ct_replace_o  = 1'b0;
    out_valid_o       = 1'b0;
    tag_valid_o       = 1'b0;
    if (is_perm(r_state)) begin
      load_state_o = 1'b1;
      rnd_idx_o    = w_idx;
    end
    case (r_state)
      ST_INIT_PERM: sel_state_init_o = r_first;
      ST_INIT_END: begin
        sel_xor_init_o    = 1'b1;
        sel_xor_dom_sep_o = (r_ad_cnt == '0);
      end
      ST_WAIT_AD, ST_WAIT_MSG, ST_WAIT_LAST: data_req_o = r_first;
      ST_AD_PERM: sel_xor_ext_o = r_first;
      ST_AD_END:  sel_xor_dom_sep_o = 1'b1;
      ST_MSG_PERM: begin
        sel_xor_ext_o    = r_first;
        out_valid_o      = r_first;
        sel_ct_replace_o = r_first && r_decrypt;
      end
      ST_FIN_PERM: begin
        sel_xor_ext_o    = r_first;
        sel_xor_fin_o    = r_first;
        out_valid_o      = r_first;
        sel_ct_replace_o = r_first && r_decrypt;
      end
      ST_FIN_END: begin
        load_state_o  = 1'b1;
        sel_xor_tag_o = 1'b1;
      end
      ST_DONE: begin
        done_o      = 1'b1;
        tag_valid_o = !r_decrypt;
      end
      default: ;
    endcase
  end

  assign auth_ok_o   = r_auth_ok;
  assign auth_fail_o = r_auth_fail;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Bench for ascon_aead_ctrl: three parameterisations checked cycle by cycle
// against a phase-schedule model, plus directed latency/pulse/verdict table.
module tb_ascon_aead_ctrl;

  localparam int NI = 3;
  localparam int RA = 12;

  typedef struct packed {
    logic ready, busy, done, load, sinit, xinit, xext, dom;
    logic fin, xtag, ct, outv, tagv, aok, afail, dreq;
    logic [3:0] rnd;
  } out_t;

  typedef struct {
    int k; bit d; int nad; int nmsg; int dl; int slast; bit tmv; bit junk;
    int e_lat; int e_req; int e_ov; int e_ok; int e_fail;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [NI];
  logic       dec   [NI];
  logic       valid [NI];
  logic       tm    [NI];
  logic [7:0] ad_b  [NI];
  logic [7:0] msg_b [NI];
  logic [7:0] dly   [NI];
  out_t       obs   [NI];

  always #5 clk = ~clk;

  // Instance 0: A12/B6/U1, instance 1: A12/B6/U2, instance 2: A12/B8/U1 (128a).
  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic w_dreq, w_rdy, w_busy, w_done, w_load, w_sinit, w_xinit, w_xext;
    logic w_dom, w_fin, w_xtag, w_ct, w_outv, w_tagv, w_aok, w_afail;
    logic [3:0] w_rnd;
    ascon_aead_ctrl #(
      .ROUNDS_A (12),
      .ROUNDS_B ((g == 2) ? 8 : 6),
      .UNROLL   ((g == 1) ? 2 : 1),
      .BLK_W    (8),
      .DELAY_W  (8)
    ) u_dut (
      .clk_i (clk), .rst_i (rst), .start_i (start[g]), .decrypt_i (dec[g]),
      .ad_blks_i (ad_b[g]), .msg_blks_i (msg_b[g]), .delay_i (dly[g]),
      .data_valid_i (valid[g]), .tag_match_i (tm[g]),
      .data_req_o (w_dreq), .ready_o (w_rdy), .busy_o (w_busy), .done_o (w_done),
      .load_state_o (w_load), .rnd_idx_o (w_rnd), .sel_state_init_o (w_sinit),
      .sel_xor_init_o (w_xinit), .sel_xor_ext_o (w_xext), .sel_xor_dom_sep_o (w_dom),
      .sel_xor_fin_o (w_fin), .sel_xor_tag_o (w_xtag), .sel_ct_replace_o (w_ct),
      .out_valid_o (w_outv), .tag_valid_o (w_tagv), .auth_ok_o (w_aok),
      .auth_fail_o (w_afail)
    );
    assign obs[g] = '{ready: w_rdy, busy: w_busy, done: w_done, load: w_load,
                      sinit: w_sinit, xinit: w_xinit, xext: w_xext, dom: w_dom,
                      fin: w_fin, xtag: w_xtag, ct: w_ct, outv: w_outv,
                      tagv: w_tagv, aok: w_aok, afail: w_afail, dreq: w_dreq,
                      rnd: w_rnd};
  end

  int   n_vec;
  int   n_err;
  out_t eq [$];
  bit   qs [$];
  bit   qv [$];
  bit   qt [$];
  out_t rest [NI];
  int   i_done;
  int   i_msg;
  bit   g_junk;
  vec_t tbl [6];

  function automatic int rb(int k); return (k == 2) ? 8 : 6; endfunction
  function automatic int ru(int k); return (k == 1) ? 2 : 1; endfunction

  function automatic out_t idle_t();
    out_t o; o = '0; o.ready = 1'b1; return o;
  endfunction

  function automatic out_t busy_t();
    out_t o; o = '0; o.busy = 1'b1; return o;
  endfunction

  task automatic push(out_t o, bit s, bit v, bit t);
    eq.push_back(o); qs.push_back(s); qv.push_back(v); qt.push_back(t);
  endtask

  // Busy cycles: start is don't-care (junk mode holds it high), tag_match random.
  task automatic push_busy(out_t o, bit v);
    push(o, g_junk ? 1'b1 : 1'($urandom), v, 1'($urandom));
  endtask

  task automatic add_perm(int r, int u, out_t extra);
    out_t o;
    for (int i = 0; i < r / u; i++) begin
      o = busy_t(); o.load = 1'b1; o.rnd = 4'(12 - r + i * u);
      if (i == 0) o = out_t'(o | extra);
      push_busy(o, 1'($urandom));
    end
  endtask

  task automatic add_wait(int stall);
    out_t o;
    for (int i = 0; i <= stall; i++) begin
      o = busy_t(); o.dreq = (i == 0);
      push_busy(o, i == stall);
    end
  endtask

  // Expected per-cycle trace; cycle 0 is the cycle in which start is presented.
  task automatic build(int k, bit d, int nad, int nmsg_raw, int dl, int smax,
                       int slast, bit tmv);
    out_t o, x;
    int nmsg;
    eq.delete(); qs.delete(); qv.delete(); qt.delete();
    nmsg = (nmsg_raw == 0) ? 1 : nmsg_raw;
    i_msg = -1;
    push(rest[k], 1'b1, 1'($urandom), 1'($urandom));
    push_busy(busy_t(), 1'($urandom));
    for (int i = 0; i < dl; i++) push_busy(busy_t(), 1'($urandom));
    x = '0; x.sinit = 1'b1;
    add_perm(RA, ru(k), x);
    o = busy_t(); o.xinit = 1'b1; o.dom = (nad == 0);
    push_busy(o, 1'($urandom));
    for (int a = 0; a < nad; a++) begin
      add_wait(int'($urandom_range(smax, 0)));
      x = '0; x.xext = 1'b1;
      add_perm(rb(k), ru(k), x);
    end
    if (nad > 0) begin
      o = busy_t(); o.dom = 1'b1; push_busy(o, 1'($urandom));
    end
    for (int m = 1; m < nmsg; m++) begin
      add_wait(int'($urandom_range(smax, 0)));
      x = '0; x.xext = 1'b1; x.outv = 1'b1; x.ct = d;
      if (m == 1) i_msg = eq.size();
      add_perm(rb(k), ru(k), x);
    end
    add_wait((slast >= 0) ? slast : int'($urandom_range(smax, 0)));
    x = '0; x.xext = 1'b1; x.fin = 1'b1; x.outv = 1'b1; x.ct = d;
    add_perm(RA, ru(k), x);
    o = busy_t(); o.load = 1'b1; o.xtag = 1'b1; push_busy(o, 1'($urandom));
    if (d) push(busy_t(), g_junk ? 1'b1 : 1'($urandom), 1'($urandom), tmv);
    o = '0; o.ready = 1'b1; o.done = 1'b1; o.tagv = !d;
    o.aok = d && tmv; o.afail = d && !tmv;
    i_done = eq.size();
    for (int i = 0; i < 3; i++) push(o, 1'b0, 1'($urandom), 1'($urandom));
    rest[k] = o;
  endtask

  task automatic chk_out(string nm, out_t act, out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Latency = edges from the start-sampling edge to the edge that raises done_o.
  task automatic run(int k, int nmax, output int lat, output int nreq, output int nov);
    lat = -1; nreq = 0; nov = 0;
    for (int i = 0; i < eq.size() && i < nmax; i++) begin
      @(negedge clk);
      chk_out($sformatf("trace inst%0d cyc%0d", k, i), obs[k], eq[i]);
      if (i > 0) begin
        if (obs[k].done && lat < 0) lat = i - 1;
        if (obs[k].dreq) nreq++;
        if (obs[k].outv) nov++;
      end
      start[k] = qs[i]; valid[k] = qv[i]; tm[k] = qt[i];
    end
  endtask

  task automatic cfg(int k, bit d, int nad, int nmsg, int dl);
    dec[k] = d; ad_b[k] = 8'(nad); msg_b[k] = 8'(nmsg); dly[k] = 8'(dl);
  endtask

  initial begin
    int lat, nreq, nov;
    int k, nad, nmsg, dl;
    bit d, tmv;
    n_vec = 0; n_err = 0; g_junk = 1'b0;
    rst = 1'b1;
    for (int j = 0; j < NI; j++) begin
      start[j] = 1'b0; dec[j] = 1'b0; valid[j] = 1'b0; tm[j] = 1'b0;
      ad_b[j] = '0; msg_b[j] = '0; dly[j] = '0; rest[j] = idle_t();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < NI; j++) chk_out($sformatf("reset inst%0d", j), obs[j], idle_t());
    rst = 1'b0;

    //             k  d  ad msg dl slast tm junk lat req ov ok fail
    tbl[0] = '{0, 1'b0, 0, 1, 0, 0,  1'b0, 1'b0, 28, 1, 1, 0, 0};
    tbl[1] = '{1, 1'b0, 2, 3, 0, 0,  1'b0, 1'b0, 33, 5, 3, 0, 0};
    tbl[2] = '{2, 1'b1, 1, 2, 0, 0,  1'b1, 1'b0, 48, 3, 2, 1, 0};
    tbl[3] = '{2, 1'b1, 1, 2, 0, 0,  1'b0, 1'b0, 48, 3, 2, 0, 1};
    tbl[4] = '{0, 1'b0, 0, 1, 5, 10, 1'b0, 1'b1, 43, 1, 1, 0, 0};
    tbl[5] = '{0, 1'b0, 0, 0, 0, 0,  1'b0, 1'b0, 28, 1, 1, 0, 0};

    for (int t = 0; t < 6; t++) begin
      g_junk = tbl[t].junk;
      build(tbl[t].k, tbl[t].d, tbl[t].nad, tbl[t].nmsg, tbl[t].dl, 0, tbl[t].slast, tbl[t].tmv);
      cfg(tbl[t].k, tbl[t].d, tbl[t].nad, tbl[t].nmsg, tbl[t].dl);
      run(tbl[t].k, 1 << 20, lat, nreq, nov);
      chk($sformatf("row%0d latency", t), lat, tbl[t].e_lat);
      chk($sformatf("row%0d data_req pulses", t), nreq, tbl[t].e_req);
      chk($sformatf("row%0d out_valid pulses", t), nov, tbl[t].e_ov);
      chk($sformatf("row%0d auth_ok", t), int'(obs[tbl[t].k].aok), tbl[t].e_ok);
      chk($sformatf("row%0d auth_fail", t), int'(obs[tbl[t].k].afail), tbl[t].e_fail);
    end
    g_junk = 1'b0;

    for (int t = 0; t < 20; t++) begin
      k = int'($urandom_range(NI - 1, 0));
      d = 1'($urandom); tmv = 1'($urandom);
      nad = int'($urandom_range(3, 0)); nmsg = int'($urandom_range(3, 0));
      dl = int'($urandom_range(3, 0));
      build(k, d, nad, nmsg, dl, 3, -1, tmv);
      cfg(k, d, nad, nmsg, dl);
      run(k, 1 << 20, lat, nreq, nov);
      chk($sformatf("rand%0d latency", t), lat, i_done - 1);
    end

    // Synchronous reset landing in the second MSG_PERM cycle.
    build(1, 1'b0, 0, 2, 0, 0, 0, 1'b0);
    cfg(1, 1'b0, 0, 2, 0);
    run(1, i_msg + 2, lat, nreq, nov);
    rst = 1'b1;
    for (int j = 0; j < NI; j++) start[j] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < NI; j++) begin
      chk_out($sformatf("mid-op reset inst%0d", j), obs[j], idle_t());
      rest[j] = idle_t();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_out($sformatf("post-reset idle cyc%0d", c), obs[1], idle_t());
    end
    build(1, 1'b0, 0, 1, 0, 0, 0, 1'b0);
    cfg(1, 1'b0, 0, 1, 0);
    run(1, 1 << 20, lat, nreq, nov);
    chk("post-reset latency", lat, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
